// File: rtl/trap_if.sv
// Bus between the MEM stage and the machine-mode trap controller: trap sources,
// CSR access port, and the redirect / flush / write-back-cancel outputs.
interface trap_if #(
   parameter int XLEN    = 32,
   parameter int NUM_IRQ = 4
);
   // inst_valid qualifies every trap source and mret; there is no backpressure, so
   // a request is accepted in the cycle it is presented if the controller is in RUN.
   logic [NUM_IRQ-1:0] irq;
   logic               inst_valid;
   logic               illegal_inst;
   logic               ecall_m;
   logic               l_access_fault;
   logic               s_access_fault;
   logic               mret;
   logic [XLEN-1:0]    epc_cur;
   logic [XLEN-1:0]    epc_next;
   logic               csr_rw;
   logic [1:0]         csr_wsc;
   logic [11:0]        csr_addr;
   logic [XLEN-1:0]    csr_wdata;
   logic [XLEN-1:0]    csr_rdata;
   logic [XLEN-1:0]    PC_redirect;
   logic               redirect_mux;
   logic               reg_FD_flush;
   logic               reg_DE_flush;
   logic               reg_EM_flush;
   logic               reg_MW_flush;
   logic               RegWrite_cancel;
   logic               dbg_state;

   modport slave (
      input  irq, inst_valid, illegal_inst, ecall_m, l_access_fault, s_access_fault,
      input  mret, epc_cur, epc_next, csr_rw, csr_wsc, csr_addr, csr_wdata,
      output csr_rdata, PC_redirect, redirect_mux, reg_FD_flush, reg_DE_flush,
      output reg_EM_flush, reg_MW_flush, RegWrite_cancel, dbg_state
   );

   modport master (
      output irq, inst_valid, illegal_inst, ecall_m, l_access_fault, s_access_fault,
      output mret, epc_cur, epc_next, csr_rw, csr_wsc, csr_addr, csr_wdata,
      input  csr_rdata, PC_redirect, redirect_mux, reg_FD_flush, reg_DE_flush,
      input  reg_EM_flush, reg_MW_flush, RegWrite_cancel, dbg_state
   );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap controller: prioritised exceptions and interrupts, M-mode CSR
// file, combinational PC redirect/flush, and a one-cycle BLANK state after each redirect.
module trap_unit #(
   parameter int XLEN     = 32,
   parameter int NUM_IRQ  = 4,
   parameter int IRQ_EDGE = 0
) (
   input logic   clk,
   input logic   rst,
   trap_if.slave bus
);
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   typedef enum logic {RUN = 1'b0, BLANK = 1'b1} state_e;

   state_e           state_q, state_d;
   logic             mstatus_mie_q, mstatus_mpie_q;
   logic [XLEN-1:0]  mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;
   logic [NUM_IRQ-1:0] pend;

   logic             active, exc, irq_hit, irq_take, trap, do_mret, csr_we;
   logic [4:0]       exc_code, irq_code, cause_code;
   logic [XLEN-1:0]  pend_xl, rdata, wval, base, target, cause_val;

   assign active = bus.inst_valid && (state_q == RUN) && !rst;
   assign exc    = active && (bus.illegal_inst || bus.ecall_m ||
                              bus.l_access_fault || bus.s_access_fault);

   always_comb begin
      if (bus.illegal_inst)      exc_code = 5'd2;
      else if (bus.ecall_m)      exc_code = 5'd11;
      else if (bus.l_access_fault) exc_code = 5'd5;
      else                       exc_code = 5'd7;
   end

   // Walk from the top line down so the lowest enabled pending line wins.
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = 5'd0;
      pend_xl  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         pend_xl[16 + i] = pend[i];
         if (pend[i] && mie_q[16 + i]) begin
            irq_hit  = 1'b1;
            irq_code = 5'(16 + i);
         end
      end
   end

   assign irq_take   = active && !exc && mstatus_mie_q && irq_hit;
   assign trap       = exc || irq_take;
   assign do_mret    = active && bus.mret && !trap;
   assign csr_we     = bus.csr_rw && (bus.csr_wsc != 2'b00) && (state_q == RUN) && !trap && !rst;
   assign cause_code = exc ? exc_code : irq_code;
   assign cause_val  = {irq_take, {(XLEN-6){1'b0}}, cause_code};
   assign base       = {mtvec_q[XLEN-1:2], 2'b00};
   assign target     = (irq_take && mtvec_q[1:0] == 2'b01)
                       ? base + {{(XLEN-7){1'b0}}, cause_code, 2'b00} : base;

   assign bus.PC_redirect     = trap ? target : (do_mret ? mepc_q : '0);
   assign bus.redirect_mux    = trap || do_mret;
   assign bus.reg_FD_flush    = trap || do_mret;
   assign bus.reg_DE_flush    = trap || do_mret;
   assign bus.reg_EM_flush    = trap || do_mret;
   assign bus.reg_MW_flush    = trap || do_mret;
   assign bus.RegWrite_cancel = trap;
   assign bus.dbg_state       = state_q;

   always_comb begin
      rdata = '0;
      case (bus.csr_addr)
         CSR_MSTATUS: begin
            rdata[3] = mstatus_mie_q;
            rdata[7] = mstatus_mpie_q;
         end
         CSR_MIE:    rdata = mie_q;
         CSR_MTVEC:  rdata = mtvec_q;
         CSR_MEPC:   rdata = mepc_q;
         CSR_MCAUSE: rdata = mcause_q;
         CSR_MTVAL:  rdata = mtval_q;
         CSR_MIP:    rdata = pend_xl;
         default:    rdata = '0;
      endcase
   end
   assign bus.csr_rdata = rdata;

   always_comb begin
      case (bus.csr_wsc)
         2'b01:   wval = bus.csr_wdata;
         2'b10:   wval = rdata | bus.csr_wdata;
         2'b11:   wval = rdata & ~bus.csr_wdata;
         default: wval = rdata;
      endcase
   end

   assign state_d = (state_q == RUN && (trap || do_mret)) ? BLANK : RUN;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else begin
         if (csr_we) begin
            case (bus.csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie_q  <= wval[3];
                  mstatus_mpie_q <= wval[7];
               end
               CSR_MIE:    mie_q    <= wval;
               CSR_MTVEC:  mtvec_q  <= wval;
               CSR_MEPC:   mepc_q   <= {wval[XLEN-1:2], 2'b00};
               CSR_MCAUSE: mcause_q <= wval;
               CSR_MTVAL:  mtval_q  <= wval;
               default: ;
            endcase
         end
         if (trap) begin
            mepc_q         <= exc ? {bus.epc_cur[XLEN-1:2], 2'b00}
                                  : {bus.epc_next[XLEN-1:2], 2'b00};
            mcause_q       <= cause_val;
            mtval_q        <= exc ? bus.epc_cur : '0;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (do_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end
         state_q <= state_d;
      end
   end

   generate
      if (IRQ_EDGE != 0) begin : g_edge
         logic [NUM_IRQ-1:0] pend_q, irq_prev_q;
         // A new rising edge beats the clear of an interrupt taken on the same edge.
         always_ff @(posedge clk) begin
            if (rst) begin
               pend_q     <= '0;
               irq_prev_q <= '0;
            end else begin
               irq_prev_q <= bus.irq;
               for (int i = 0; i < NUM_IRQ; i++) begin
                  pend_q[i] <= (bus.irq[i] && !irq_prev_q[i]) ||
                               (pend_q[i] && !(irq_take && irq_code == 5'(16 + i)));
               end
            end
         end
         assign pend = pend_q;
      end else begin : g_level
         assign pend = bus.irq;
      end
   endgenerate
endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: level and edge instances share stimulus; a per-cycle
// monitor pops expected redirects and CSR read data from queues filled by the driver.
module tb_trap_unit;
   localparam int XLEN    = 32;
   localparam int NUM_IRQ = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NUM_IRQ-1:0] irq;
   logic               inst_valid, illegal_inst, ecall_m, l_access_fault, s_access_fault, mret, csr_rw;
   logic [XLEN-1:0]    epc_cur, epc_next, csr_wdata;
   logic [1:0]         csr_wsc;
   logic [11:0]        csr_addr;

   trap_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) il ();
   trap_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) ie ();

   assign il.irq = irq;                       assign ie.irq = irq;
   assign il.inst_valid = inst_valid;         assign ie.inst_valid = inst_valid;
   assign il.illegal_inst = illegal_inst;     assign ie.illegal_inst = illegal_inst;
   assign il.ecall_m = ecall_m;               assign ie.ecall_m = ecall_m;
   assign il.l_access_fault = l_access_fault; assign ie.l_access_fault = l_access_fault;
   assign il.s_access_fault = s_access_fault; assign ie.s_access_fault = s_access_fault;
   assign il.mret = mret;                     assign ie.mret = mret;
   assign il.epc_cur = epc_cur;               assign ie.epc_cur = epc_cur;
   assign il.epc_next = epc_next;             assign ie.epc_next = epc_next;
   assign il.csr_rw = csr_rw;                 assign ie.csr_rw = csr_rw;
   assign il.csr_wsc = csr_wsc;               assign ie.csr_wsc = csr_wsc;
   assign il.csr_addr = csr_addr;             assign ie.csr_addr = csr_addr;
   assign il.csr_wdata = csr_wdata;           assign ie.csr_wdata = csr_wdata;

   trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_EDGE(0)) dut_l (.clk(clk), .rst(rst), .bus(il));
   trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_EDGE(1)) dut_e (.clk(clk), .rst(rst), .bus(ie));

   // Scoreboard: redirect entries are {RegWrite_cancel, PC_redirect}.
   logic [32:0] exp_redir_l_q[$], exp_redir_e_q[$];
   logic [31:0] exp_rd_l_q[$], exp_rd_e_q[$];
   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endfunction

   function automatic void monitor(input int d, input logic mux, input logic [3:0] fl,
                                   input logic cancel, input logic [31:0] pc,
                                   input logic rd, input logic [31:0] rdata);
      string tag;
      logic [32:0] er;
      logic [31:0] ed;
      int n;
      tag = (d == 0) ? "lvl" : "edg";
      if (mux) begin
         n = (d == 0) ? exp_redir_l_q.size() : exp_redir_e_q.size();
         if (n == 0) chk({tag, "_unexpected_redirect"}, 40'(mux), 40'd0);
         else begin
            if (d == 0) er = exp_redir_l_q.pop_front();
            else        er = exp_redir_e_q.pop_front();
            chk({tag, "_redirect"}, {7'd0, cancel, pc}, {7'd0, er});
            chk({tag, "_flush"}, 40'(fl), 40'hf);
         end
      end else begin
         chk({tag, "_quiet"}, {3'd0, fl, cancel, pc}, 40'd0);
      end
      if (rd) begin
         n = (d == 0) ? exp_rd_l_q.size() : exp_rd_e_q.size();
         if (n == 0) chk({tag, "_unexpected_read"}, 40'(rd), 40'd0);
         else begin
            if (d == 0) ed = exp_rd_l_q.pop_front();
            else        ed = exp_rd_e_q.pop_front();
            chk({tag, "_csr_rdata"}, 40'(rdata), 40'(ed));
         end
      end
   endfunction

   always @(negedge clk) begin
      monitor(0, il.redirect_mux, {il.reg_FD_flush, il.reg_DE_flush, il.reg_EM_flush, il.reg_MW_flush},
              il.RegWrite_cancel, il.PC_redirect, il.csr_rw && il.csr_wsc == 2'b00, il.csr_rdata);
      monitor(1, ie.redirect_mux, {ie.reg_FD_flush, ie.reg_DE_flush, ie.reg_EM_flush, ie.reg_MW_flush},
              ie.RegWrite_cancel, ie.PC_redirect, ie.csr_rw && ie.csr_wsc == 2'b00, ie.csr_rdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_valid = 0; illegal_inst = 0; ecall_m = 0; l_access_fault = 0; s_access_fault = 0;
      mret = 0; csr_rw = 0; csr_wsc = 2'b00; csr_addr = '0; csr_wdata = '0;
      epc_cur = '0; epc_next = '0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
      idle();
      inst_valid = 1; csr_rw = 1; csr_wsc = op; csr_addr = a; csr_wdata = v;
      tick();
      idle();
   endtask

   task automatic csr_rd2(input logic [11:0] a, input logic [31:0] exp_l, input logic [31:0] exp_e);
      idle();
      inst_valid = 1; csr_rw = 1; csr_addr = a;
      exp_rd_l_q.push_back(exp_l);
      exp_rd_e_q.push_back(exp_e);
      tick();
      idle();
   endtask

   task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp_v);
      csr_rd2(a, exp_v, exp_v);
   endtask

   task automatic expect_redir(input logic to_l, input logic to_e, input logic cancel, input logic [31:0] pc);
      if (to_l) exp_redir_l_q.push_back({cancel, pc});
      if (to_e) exp_redir_e_q.push_back({cancel, pc});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      irq = '0;
      idle();
      rst = 1;
      inst_valid = 1; illegal_inst = 1; epc_cur = 32'h10;
      repeat (3) tick();
      rst = 0;
      idle();
      tick();

      // Reset state and unmapped address
      csr_rd(12'h300, 32'h0);
      csr_rd(12'h305, 32'h0);
      csr_rd(12'h342, 32'h0);
      csr_wr(12'h7C0, 2'b01, 32'hFFFF);
      csr_rd(12'h7C0, 32'h0);

      // Illegal instruction, direct mode
      csr_wr(12'h305, 2'b01, 32'h100);
      csr_rd(12'h305, 32'h100);
      inst_valid = 1; illegal_inst = 1; epc_cur = 32'h40; epc_next = 32'h44;
      expect_redir(1, 1, 1, 32'h100);
      tick();
      csr_rd(12'h342, 32'h2);
      csr_rd(12'h341, 32'h40);
      csr_rd(12'h343, 32'h40);
      csr_rd(12'h300, 32'h0);

      // Vectored interrupt on line 1
      csr_wr(12'h305, 2'b01, 32'h201);
      csr_wr(12'h304, 2'b01, 32'h2_0000);
      csr_wr(12'h300, 2'b01, 32'h8);
      irq = 4'b0010;
      tick();
      inst_valid = 1; epc_cur = 32'h80; epc_next = 32'h84;
      expect_redir(1, 1, 1, 32'h244);
      tick();
      csr_rd(12'h342, 32'h8000_0011);
      csr_rd(12'h341, 32'h84);
      csr_rd(12'h343, 32'h0);
      csr_rd(12'h300, 32'h80);
      irq = '0;
      csr_rd(12'h344, 32'h0);

      // Priority: exception first, then line 0 before line 2
      csr_wr(12'h304, 2'b01, 32'h5_0000);
      csr_wr(12'h300, 2'b01, 32'h8);
      irq = 4'b0101;
      tick();
      inst_valid = 1; ecall_m = 1; epc_cur = 32'h90; epc_next = 32'h94;
      expect_redir(1, 1, 1, 32'h200);
      tick();
      csr_rd(12'h342, 32'hB);
      csr_wr(12'h300, 2'b10, 32'h8);
      inst_valid = 1; epc_cur = 32'hA0; epc_next = 32'hA4;
      expect_redir(1, 1, 1, 32'h240);
      tick();
      csr_rd(12'h342, 32'h8000_0010);
      irq = 4'b0100;
      csr_wr(12'h300, 2'b10, 32'h8);
      inst_valid = 1; epc_cur = 32'hA4; epc_next = 32'hA8;
      expect_redir(1, 1, 1, 32'h248);
      tick();
      csr_rd(12'h342, 32'h8000_0012);
      csr_rd(12'h300, 32'h80);
      irq = '0;

      // mret, mepc alignment, write ignored in BLANK
      csr_wr(12'h341, 2'b01, 32'h87);
      csr_rd(12'h341, 32'h84);
      inst_valid = 1; mret = 1;
      expect_redir(1, 1, 0, 32'h84);
      tick();
      csr_wr(12'h305, 2'b01, 32'h300);
      csr_rd(12'h305, 32'h201);
      csr_rd(12'h300, 32'h88);

      // CSR set colliding with a store fault (and an mret that must lose)
      inst_valid = 1; csr_rw = 1; csr_wsc = 2'b10; csr_addr = 12'h304; csr_wdata = 32'h2_0000;
      s_access_fault = 1; mret = 1; epc_cur = 32'hC0; epc_next = 32'hC4;
      expect_redir(1, 1, 1, 32'h200);
      tick();
      csr_rd(12'h342, 32'h7);
      csr_rd(12'h304, 32'h5_0000);
      csr_rd(12'h343, 32'hC0);
      csr_rd(12'h300, 32'h80);

      // Reset asserted in the BLANK cycle after a trap
      inst_valid = 1; illegal_inst = 1; epc_cur = 32'hD0; epc_next = 32'hD4;
      expect_redir(1, 1, 1, 32'h200);
      tick();
      idle();
      rst = 1; inst_valid = 1; ecall_m = 1; epc_cur = 32'hE0;
      tick();
      rst = 0;
      idle();
      csr_rd(12'h300, 32'h0);
      csr_rd(12'h304, 32'h0);
      csr_rd(12'h305, 32'h0);
      csr_rd(12'h341, 32'h0);
      csr_rd(12'h342, 32'h0);
      csr_rd(12'h343, 32'h0);
      csr_rd(12'h344, 32'h0);

      // Edge capture of a one-cycle pulse; mtvec mode 2'b10 behaves as direct
      csr_wr(12'h305, 2'b01, 32'h302);
      csr_wr(12'h304, 2'b01, 32'h1_0000);
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      tick();
      csr_rd2(12'h344, 32'h0, 32'h1_0000);
      csr_rd2(12'h344, 32'h0, 32'h1_0000);
      csr_wr(12'h300, 2'b01, 32'h8);
      inst_valid = 1; epc_cur = 32'hE0; epc_next = 32'hE4;
      expect_redir(0, 1, 1, 32'h300);
      tick();
      csr_rd2(12'h344, 32'h0, 32'h0);
      csr_rd2(12'h342, 32'h0, 32'h8000_0010);
      csr_rd2(12'h341, 32'h0, 32'hE4);

      idle();
      repeat (2) tick();
      chk("lvl_redirect_left", 40'(exp_redir_l_q.size()), 40'd0);
      chk("edg_redirect_left", 40'(exp_redir_e_q.size()), 40'd0);
      chk("lvl_read_left", 40'(exp_rd_l_q.size()), 40'd0);
      chk("edg_read_left", 40'(exp_rd_e_q.size()), 40'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
